// File: rtl/pwm_pkg.sv
// Shared types and default constants for the PWM ramp controller.
// Optional feature macro: PWM_CLAMP_EN (clamps accepted targets to [DUTY_MIN, DUTY_MAX]).
package pwm_pkg;

    localparam int CBITS_DEF    = 11;
    localparam int NCH_DEF      = 4;
    localparam int DUTY_MIN_DEF = 64;
    localparam int DUTY_MAX_DEF = 1984;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_WRAP = 2'd1,
        DONE      = 2'd2
    } ramp_state_t;

    typedef logic [CBITS_DEF-1:0] duty_t;

endpackage

// File: rtl/pwm_ramp_ctrl_if.sv
// Command channel of the PWM ramp controller.
// valid/ready: a command transfers on a rising clk edge where cmd_valid and
// cmd_ready are both high; the master holds cmd_ch/cmd_duty/cmd_step stable
// while cmd_valid is high, and cmd_ready never depends on cmd_valid.
interface pwm_ramp_ctrl_if #(
    parameter int NCH   = 4,
    parameter int CBITS = 11
);
    localparam int CHW = $clog2(NCH);

    logic             cmd_valid;
    logic             cmd_ready;
    logic [CHW-1:0]   cmd_ch;
    logic [CBITS-1:0] cmd_duty;
    logic [CBITS-1:0] cmd_step;

    modport master (
        output cmd_valid,
        output cmd_ch,
        output cmd_duty,
        output cmd_step,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_ch,
        input  cmd_duty,
        input  cmd_step,
        output cmd_ready
    );

endinterface

// File: rtl/pwm_channel.sv
// One PWM channel: holds the active duty and the registered compare output.
// The duty only changes when the sequencer pulses load_en (at a period wrap).
module pwm_channel #(
    parameter int CBITS = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CBITS-1:0] cnt,
    input  logic             load_en,
    input  logic [CBITS-1:0] load_val,
    output logic [CBITS-1:0] act,
    output logic             pwm
);

    logic [CBITS-1:0] act_q, act_d;
    logic             pwm_q, pwm_d;

    // Next duty and next compare result.
    always_comb begin
        act_d = act_q;
        if (load_en) begin
            act_d = load_val;
        end
        pwm_d = (cnt < act_q);
    end

    // Duty and output registers; reset drops the output and forgets the duty.
    always_ff @(posedge clk) begin
        if (rst) begin
            act_q <= '0;
            pwm_q <= 1'b0;
        end else begin
            act_q <= act_d;
            pwm_q <= pwm_d;
        end
    end

    assign act = act_q;
    assign pwm = pwm_q;

endmodule

// File: rtl/pwm_ramp_ctrl.sv
// Multi-channel PWM generator with a command-driven duty ramp sequencer.
// A shared free-running counter drives NCH compare channels; one FSM steps a
// single channel's duty toward a target once per period, at the wrap edge.
// Optional feature macro: PWM_CLAMP_EN (adds DUTY_MIN/DUTY_MAX and clamps targets).
module pwm_ramp_ctrl
    import pwm_pkg::*;
#(
    parameter int CBITS    = CBITS_DEF,
    parameter int NCH      = NCH_DEF
`ifdef PWM_CLAMP_EN
    ,
    parameter int DUTY_MIN = DUTY_MIN_DEF,
    parameter int DUTY_MAX = DUTY_MAX_DEF
`endif
) (
    input  logic                        clk,
    input  logic                        rst,
    pwm_ramp_ctrl_if.slave              cmd,
    output logic                        busy,
    output logic                        done,
    output logic                        wrap,
    output logic [NCH-1:0]              pwm_out,
    output logic [NCH-1:0][CBITS-1:0]   act_dbg,
    output ramp_state_t                 state_dbg
);

    localparam int CHW = $clog2(NCH);

    // Period counter.
    logic [CBITS-1:0] cnt_q, cnt_d;

    // Sequencer state and latched command.
    ramp_state_t      state_q, state_d;
    logic [CHW-1:0]   ch_q, ch_d;
    logic [CBITS-1:0] tgt_q, tgt_d;
    logic [CBITS-1:0] step_q, step_d;

    // Channel interface.
    logic [NCH-1:0]            load_en;
    logic [NCH-1:0][CBITS-1:0] act;

    // Step arithmetic.
    logic [CBITS-1:0] tgt_in;
    logic [CBITS-1:0] cur;
    logic [CBITS:0]   cur_w, tgt_w, step_w, sum_w, dist_w;
    logic [CBITS-1:0] nxt;
    logic             ch_ok;

    // Free-running period counter; wraps naturally at 2^CBITS.
    always_comb begin
        cnt_d = cnt_q + 1'b1;
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign wrap = &cnt_q;

    // Target as latched at acceptance, optionally clamped to the safe window.
    always_comb begin
`ifdef PWM_CLAMP_EN
        if (cmd.cmd_duty < CBITS'(DUTY_MIN)) begin
            tgt_in = CBITS'(DUTY_MIN);
        end else if (cmd.cmd_duty > CBITS'(DUTY_MAX)) begin
            tgt_in = CBITS'(DUTY_MAX);
        end else begin
            tgt_in = cmd.cmd_duty;
        end
`else
        tgt_in = cmd.cmd_duty;
`endif
    end

    // Move the ramped channel's duty one step toward the target, saturating
    // at the target; the extra bit keeps act +/- step from wrapping.
    always_comb begin
        cur = '0;
        for (int i = 0; i < NCH; i++) begin
            if (ch_q == CHW'(i)) begin
                cur = act[i];
            end
        end
        cur_w  = {1'b0, cur};
        tgt_w  = {1'b0, tgt_q};
        step_w = {1'b0, step_q};
        sum_w  = cur_w + step_w;
        dist_w = cur_w - tgt_w;
        if (step_q == '0) begin
            nxt = tgt_q;
        end else if (tgt_w > cur_w) begin
            nxt = (sum_w >= tgt_w) ? tgt_q : sum_w[CBITS-1:0];
        end else begin
            nxt = (step_w >= dist_w) ? tgt_q : (cur - step_q);
        end
    end

    // Channel indices at or above NCH are accepted but never touch a channel.
    assign ch_ok = ({1'b0, cmd.cmd_ch} < (CHW+1)'(NCH));

    // Sequencer next-state, command latch and channel load strobes.
    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        tgt_d   = tgt_q;
        step_d  = step_q;
        load_en = '0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (cmd.cmd_valid) begin
                    ch_d    = cmd.cmd_ch;
                    tgt_d   = tgt_in;
                    step_d  = cmd.cmd_step;
                    state_d = ch_ok ? WAIT_WRAP : DONE;
                end
            end
            WAIT_WRAP: begin
                if (wrap) begin
                    for (int i = 0; i < NCH; i++) begin
                        load_en[i] = (ch_q == CHW'(i));
                    end
                    if (nxt == tgt_q) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Sequencer state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Latched command fields.
    always_ff @(posedge clk) begin
        if (rst) begin
            ch_q   <= '0;
            tgt_q  <= '0;
            step_q <= '0;
        end else begin
            ch_q   <= ch_d;
            tgt_q  <= tgt_d;
            step_q <= step_d;
        end
    end

    assign cmd.cmd_ready = (state_q == IDLE);
    assign busy          = (state_q != IDLE);
    assign state_dbg     = state_q;
    assign act_dbg       = act;

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        pwm_channel #(
            .CBITS (CBITS)
        ) u_ch (
            .clk      (clk),
            .rst      (rst),
            .cnt      (cnt_q),
            .load_en  (load_en[g]),
            .load_val (nxt),
            .act      (act[g]),
            .pwm      (pwm_out[g])
        );
    end

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Self-checking bench for pwm_ramp_ctrl: directed scenarios plus random
// ramps, all compared every cycle against a period-level behavioural model.
// NCH = 3 so that an out-of-range channel index (3) can be driven.
module tb_pwm_ramp_ctrl;
    import pwm_pkg::*;

    localparam int CBITS  = 11;
    localparam int NCH    = 3;
    localparam int CHW    = $clog2(NCH);
    localparam int PERIOD = 1 << CBITS;
    localparam int TMAX   = 6 * PERIOD;
`ifdef PWM_CLAMP_EN
    localparam bit CLAMP_ON = 1'b1;
`else
    localparam bit CLAMP_ON = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pwm_ramp_ctrl_if #(.NCH(NCH), .CBITS(CBITS)) cmd_if ();

    logic                      busy;
    logic                      done;
    logic                      wrap;
    logic [NCH-1:0]            pwm_out;
    logic [NCH-1:0][CBITS-1:0] act_dbg;
    ramp_state_t               state_dbg;

    pwm_ramp_ctrl #(.CBITS(CBITS), .NCH(NCH)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd       (cmd_if),
        .busy      (busy),
        .done      (done),
        .wrap      (wrap),
        .pwm_out   (pwm_out),
        .act_dbg   (act_dbg),
        .state_dbg (state_dbg)
    );

    // ---------------- scoreboard bookkeeping ----------------
    int n_checks = 0;
    int n_fails  = 0;
    logic [CBITS-1:0] exp_q[$];
    duty_t            got_q[$];

    function automatic void chk(string name, logic [31:0] actual, logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endfunction

    // ---------------- behavioural model ----------------
    // Per period boundary: the ramped channel's duty moves toward the target
    // by step (or jumps when step is 0), never overshooting.
    int          m_cnt;
    int          m_act[NCH];
    logic [NCH-1:0] m_pwm;
    bit          m_busy;
    bit          m_done;
    int          m_ch, m_tgt, m_step;
    bit          live = 1'b0;

    function automatic int clamp_duty(int d);
        if (!CLAMP_ON) return d;
        if (d < DUTY_MIN_DEF) return DUTY_MIN_DEF;
        if (d > DUTY_MAX_DEF) return DUTY_MAX_DEF;
        return d;
    endfunction

    function automatic int toward(int cur, int tgt, int step);
        if (step == 0) return tgt;
        if (tgt > cur) return (tgt - cur <= step) ? tgt : cur + step;
        if (tgt < cur) return (cur - tgt <= step) ? tgt : cur - step;
        return tgt;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_cnt  = 0;
            m_pwm  = '0;
            m_busy = 1'b0;
            m_done = 1'b0;
            m_ch   = 0;
            m_tgt  = 0;
            m_step = 0;
            for (int i = 0; i < NCH; i++) m_act[i] = 0;
        end else begin
            for (int i = 0; i < NCH; i++) m_pwm[i] = (m_cnt < m_act[i]);
            if (m_done) begin
                m_done = 1'b0;
                m_busy = 1'b0;
            end else if (m_busy) begin
                if (m_cnt == PERIOD - 1) begin
                    m_act[m_ch] = toward(m_act[m_ch], m_tgt, m_step);
                    if (m_act[m_ch] == m_tgt) m_done = 1'b1;
                end
            end else if (cmd_if.cmd_valid) begin
                m_ch   = int'(cmd_if.cmd_ch);
                m_tgt  = clamp_duty(int'(cmd_if.cmd_duty));
                m_step = int'(cmd_if.cmd_step);
                m_busy = 1'b1;
                if (m_ch >= NCH) m_done = 1'b1;
            end
            m_cnt = (m_cnt + 1) % PERIOD;
        end
        live = 1'b1;
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (live) begin
            ramp_state_t exp_state;
            exp_state = !m_busy ? IDLE : (m_done ? DONE : WAIT_WRAP);
            chk("cmd_ready", 32'(cmd_if.cmd_ready), 32'(!m_busy));
            chk("busy", 32'(busy), 32'(m_busy));
            chk("done", 32'(done), 32'(m_done));
            chk("wrap", 32'(wrap), 32'(m_cnt == PERIOD - 1));
            chk("pwm_out", 32'(pwm_out), 32'(m_pwm));
            chk("state", 32'(state_dbg), 32'(exp_state));
            for (int i = 0; i < NCH; i++) begin
                chk($sformatf("act[%0d]", i), 32'(act_dbg[i]), 32'(m_act[i]));
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Called at a negedge; returns at the negedge after the accept edge.
    task automatic send_cmd(int ch, int duty, int step);
        int n = 0;
        cmd_if.cmd_ch    = CHW'(ch);
        cmd_if.cmd_duty  = CBITS'(duty);
        cmd_if.cmd_step  = CBITS'(step);
        cmd_if.cmd_valid = 1'b1;
        while (!cmd_if.cmd_ready && n < TMAX) begin
            @(negedge clk);
            n++;
        end
        chk("accept_wait", 32'(n < TMAX), 32'd1);
        @(negedge clk);
        cmd_if.cmd_valid = 1'b0;
    endtask

    task automatic wait_done(output int cycles);
        int n = 0;
        while (!done && n < TMAX) begin
            @(negedge clk);
            n++;
        end
        chk("done_wait", 32'(n < TMAX), 32'd1);
        cycles = n;
    endtask

    // Record the channel's duty right after each wrap edge until done.
    task automatic collect_ramp(int ch);
        bit after_wrap = 1'b0;
        int n = 0;
        got_q.delete();
        while (n < TMAX) begin
            if (after_wrap) got_q.push_back(act_dbg[ch]);
            if (done) break;
            after_wrap = wrap;
            @(negedge clk);
            n++;
        end
        chk("ramp_wait", 32'(n < TMAX), 32'd1);
    endtask

    task automatic check_seq(string name);
        chk({name, "_len"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            chk($sformatf("%s[%0d]", name, i), 32'(got_q[i]), 32'(exp_q[i]));
        end
    endtask

    // High cycles over one full period, and the output in the cycle after a wrap.
    task automatic count_high(int ch, output int hi, output logic post_wrap);
        bit prev_wrap = 1'b0;
        hi = 0;
        post_wrap = 1'bx;
        for (int i = 0; i < PERIOD; i++) begin
            @(negedge clk);
            if (pwm_out[ch]) hi++;
            if (prev_wrap) post_wrap = pwm_out[ch];
            prev_wrap = wrap;
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int cyc, hi, w, n, acc, dn, ch, duty, step, cur, d;
        logic pw;
        int snap[NCH];

        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_ch    = '0;
        cmd_if.cmd_duty  = '0;
        cmd_if.cmd_step  = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_pwm", 32'(pwm_out), 32'd0);
        chk("rst_ready", 32'(cmd_if.cmd_ready), 32'd1);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_wrap", 32'(wrap), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Reset in the middle of a ramp discards the partial duty.
        send_cmd(0, 1024, 256);
        w = 0;
        n = 0;
        while (w < 2 && n < TMAX) begin
            if (wrap) w++;
            if (w < 2) begin
                @(negedge clk);
                n++;
            end
        end
        chk("midramp_wraps", 32'(w), 32'd2);
        @(negedge clk);
        chk("midramp_act0", 32'(act_dbg[0]), 32'd512);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("postrst_pwm", 32'(pwm_out), 32'd0);
        chk("postrst_ready", 32'(cmd_if.cmd_ready), 32'd1);
        chk("postrst_act0", 32'(act_dbg[0]), 32'd0);
        dn = 0;
        for (int i = 0; i < 100; i++) begin
            if (done) dn++;
            @(negedge clk);
        end
        chk("postrst_no_done", 32'(dn), 32'd0);

        // Basic up-ramp on channel 1.
        send_cmd(1, 1024, 256);
        collect_ramp(1);
        exp_q = '{11'd256, 11'd512, 11'd768, 11'd1024};
        check_seq("up_ramp");
        count_high(1, hi, pw);
        chk("up_ramp_high", 32'(hi), 32'd1024);

        // Down-ramp with saturation on the third step.
        send_cmd(2, 1000, 0);
        wait_done(cyc);
        send_cmd(2, 100, 300);
        collect_ramp(2);
        exp_q = '{11'd700, 11'd400, 11'd100};
        check_seq("down_ramp");
        @(negedge clk);
        chk("down_busy_after", 32'(busy), 32'd0);

        // Jump, then the identical command as a no-op ramp.
        send_cmd(0, 500, 0);
        collect_ramp(0);
        exp_q = '{11'd500};
        check_seq("jump");
        send_cmd(0, 500, 0);
        collect_ramp(0);
        check_seq("noop");

        // cmd_valid held high across a whole ramp: second accept only after done.
        @(negedge clk);
        cmd_if.cmd_ch    = CHW'(1);
        cmd_if.cmd_duty  = CBITS'(1100);
        cmd_if.cmd_step  = CBITS'(0);
        cmd_if.cmd_valid = 1'b1;
        acc = 0;
        dn  = 0;
        n   = 0;
        while (acc < 2 && n < TMAX) begin
            if (done) dn++;
            if (cmd_if.cmd_ready) acc++;
            if (acc < 2) begin
                @(negedge clk);
                n++;
            end
        end
        @(negedge clk);
        cmd_if.cmd_valid = 1'b0;
        chk("hold_accepts", 32'(acc), 32'd2);
        chk("hold_dones_between", 32'(dn), 32'd1);
        wait_done(cyc);

        // Accept on the wrap edge: the update comes a full period later.
        n = 0;
        while (!(wrap && cmd_if.cmd_ready) && n < TMAX) begin
            @(negedge clk);
            n++;
        end
        chk("find_wrap", 32'(n < TMAX), 32'd1);
        send_cmd(2, 300, 0);
        chk("wrap_acc_act_hold", 32'(act_dbg[2]), 32'd100);
        wait_done(cyc);
        chk("wrap_acc_latency", 32'(cyc), 32'(PERIOD));
        chk("wrap_acc_act", 32'(act_dbg[2]), 32'd300);

        // Out-of-range channel: done right away, no duty moves.
        @(negedge clk);
        for (int i = 0; i < NCH; i++) snap[i] = int'(act_dbg[i]);
        send_cmd(NCH, 2000, 5);
        wait_done(cyc);
        chk("badch_latency", 32'(cyc), 32'd0);
        for (int i = 0; i < NCH; i++) begin
            chk($sformatf("badch_act[%0d]", i), 32'(act_dbg[i]), 32'(snap[i]));
        end

        // Extreme duties with a direct jump.
        send_cmd(0, 0, 0);
        wait_done(cyc);
        count_high(0, hi, pw);
        chk("duty_lo_high", 32'(hi), CLAMP_ON ? 32'd64 : 32'd0);
        send_cmd(0, 2047, 0);
        wait_done(cyc);
        count_high(0, hi, pw);
        chk("duty_hi_high", 32'(hi), CLAMP_ON ? 32'd1984 : 32'd2047);
        chk("duty_hi_low_after_wrap", 32'(pw), 32'd0);

        // Random ramps of at most two periods each.
        for (int k = 0; k < 5; k++) begin
            repeat ($urandom_range(0, 5)) @(negedge clk);
            ch   = int'($urandom_range(0, NCH));
            duty = int'($urandom_range(0, PERIOD - 1));
            cur  = (ch < NCH) ? m_act[ch] : 0;
            d    = clamp_duty(duty) - cur;
            if (d < 0) d = -d;
            if (d == 0) step = int'($urandom_range(0, PERIOD - 1));
            else if ($urandom_range(0, 3) == 0) step = 0;
            else step = int'($urandom_range((d + 1) / 2, PERIOD - 1));
            send_cmd(ch, duty, step);
            wait_done(cyc);
        end

        repeat (4) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
